inst_fetch_bridge: RTL and testbench
====================================

# inst_fetch_bridge

Bridges the core's instruction-ROM port (`rom_ce`/`rom_addr` out, `rom_data` in) to a variable-latency req/ack instruction bus.
- Holds the most recently fetched word in a one-entry holding register and returns it without a bus access.
- On a miss, raises a stall request. This feeds `ctrl` as `stallreq_from_if` and freezes pc/if_id until the word arrives.
- Returns NOP (32'h0) whenever it has no valid instruction.

## Interface
- `ADDR_W`, 32: instruction address width.
- `DATA_W`, 32: instruction width.
- `TIMEOUT`, 16: number of cycles `bus_req_o` may stay high without `bus_ack_i` before the request is abandoned. Minimum legal value is 2.
- `clk`  in  1  system clock; all state changes on rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `rom_ce_i`  in  1  core fetch enable.
- `rom_addr_i`  in  ADDR_W  core fetch address (pc).
- `rom_data_o`  out  DATA_W  instruction to core; combinational.
- `stallreq_o`  out  1  fetch stall request to `ctrl`; combinational.
- `misalign_o`  out  1  current fetch address has `addr[1:0]!=0`; combinational.
- `bus_req_o`  out  1  bus read request; registered.
- `bus_addr_o`  out  ADDR_W  bus read address; registered.
- `bus_rdata_i`  in  DATA_W  bus read data; valid only when `bus_ack_i`=1.
- `bus_ack_i`  in  1  bus completion strobe; one cycle per request.
- `bus_err_o`  out  1  sticky timeout flag; registered.

## Operation
**Internal state**
- `hold_valid`, `hold_addr`, `hold_data`.
- FSM state: IDLE or BUSY.
- `tcnt`: timeout counter, width `$clog2(TIMEOUT+1)`.

**Hit**
- Condition: `rom_ce_i`=1 AND aligned AND `hold_valid` AND `hold_addr==rom_addr_i`.
- Response: `rom_data_o`=`hold_data`, `stallreq_o`=0. Valid in any FSM state.

**Miss**
- Condition: `rom_ce_i`=1 AND aligned AND not hit.
- Response: `rom_data_o`=0, `stallreq_o`=1.

**Idle fetch**
- Condition: `rom_ce_i`=0.
- Response: `rom_data_o`=0, `stallreq_o`=0, `misalign_o`=0. No new request is issued.

**Misaligned fetch**
- Condition: `rom_ce_i`=1 AND `rom_addr_i[1:0]!=0`.
- Response: `misalign_o`=1, `rom_data_o`=0, `stallreq_o`=0. No bus request is issued.

**FSM**
- IDLE: on a miss, register `bus_req_o`=1 and `bus_addr_o`=`rom_addr_i`, clear `tcnt`, go to BUSY.
- BUSY: `bus_req_o` and `bus_addr_o` are held stable until the request terminates.
  - `bus_ack_i`=1: load `hold_addr`=`bus_addr_o`, `hold_data`=`bus_rdata_i`, `hold_valid`=1. Set `bus_req_o`=0 and go to IDLE.
  - No ack and `tcnt==TIMEOUT-1`: load `hold_addr`=`bus_addr_o`, `hold_data`=0 (NOP), `hold_valid`=1. Set `bus_req_o`=0, set `bus_err_o`=1, go to IDLE.
  - Otherwise: `tcnt`++.
- No new request is issued in the cycle the FSM returns to IDLE. A back-to-back miss is issued one cycle later.

**Address change while BUSY** (branch, flush, or `rom_ce_i` drop)
- The in-flight request is never cancelled.
- It completes, and its data fills the holding register.
- A new miss is then issued from IDLE if the address still differs.

**Other rules**
- `bus_ack_i` while IDLE is ignored.
- `bus_err_o` stays set until `rst`.

## Timing
**Reset values** (while `rst`=1, asynchronous)
- FSM=IDLE, `hold_valid`=0, `hold_addr`=0, `hold_data`=0, `tcnt`=0.
- `bus_req_o`=0, `bus_addr_o`=0, `bus_err_o`=0.
- Combinational outputs then follow the rules above; the first aligned fetch after reset is a miss.
- Reset mid-transaction: `bus_req_o` drops immediately, and any later ack is ignored.

**Miss latency**
- Miss seen at cycle N → `bus_req_o`=1 from N+1.
- Ack at cycle N+k (k≥1) → hit and `stallreq_o`=0 at N+k+1.
- Minimum penalty is 2 stall cycles.

**Hit latency**
- Zero cycles, purely combinational.
- The core must present the same pc while stalled.

**Timeout**
- `bus_req_o` is high for exactly TIMEOUT cycles, N+1 … N+TIMEOUT.
- At N+TIMEOUT+1: `bus_req_o`=0, `bus_err_o`=1, hit with `rom_data_o`=0.

**Simultaneity**
- An ack in the same cycle as `tcnt==TIMEOUT-1` counts as success: the data is captured and `bus_err_o` is not set.

## Test plan
- **Cold miss:** reset, then `rom_ce_i`=1, addr=0x00, bus acks 3 cycles after `bus_req_o` rises with 0x34010001 → `stallreq_o`=1 for 4 cycles; `bus_addr_o`=0x00; then `rom_data_o`=0x34010001, `stallreq_o`=0.
- **Hit without bus access:** after the cold miss, hold addr=0x00 for 5 cycles → `bus_req_o` stays 0 and `rom_data_o` is constant. Then step to 0x04 with immediate ack (data 0x00011020) → exactly 2 stall cycles, then that data appears.
- **Redirect while BUSY:** miss on 0x08, change addr to 0x40 before the ack (data 0xAAAA0000 for 0x08) → `bus_addr_o` stays 0x08 until the ack. Next, one IDLE cycle, then a request for 0x40; 0xAAAA0000 is never delivered while addr=0x40.
- **Timeout (TIMEOUT=4):** miss on 0x10, never ack → `bus_req_o` high for exactly 4 cycles. Then `bus_err_o`=1 (sticky), `rom_data_o`=0, `stallreq_o`=0. A simultaneous-ack variant sets no error.
- **Misaligned and disabled fetch:** addr=0x06 → `misalign_o`=1, `stallreq_o`=0, `rom_data_o`=0, no request. `rom_ce_i`=0 → all three outputs 0.
- **Async reset mid-request:** assert `rst` between clock edges while BUSY → `bus_req_o`=0 and `bus_err_o`=0 before the next edge. An ack after reset release leaves `hold_valid`=0, and the next fetch misses.

Source files
------------

// File: rtl/inst_fetch_bridge.sv
// Instruction-ROM port to req/ack bus bridge with a one-entry holding register.
// A hit is returned combinationally; a miss stalls the core until the bus completes or times out.
module inst_fetch_bridge #(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              rom_ce_i,
  input  logic [ADDR_W-1:0] rom_addr_i,
  output logic [DATA_W-1:0] rom_data_o,
  output logic              stallreq_o,
  output logic              misalign_o,
  output logic              bus_req_o,
  output logic [ADDR_W-1:0] bus_addr_o,
  input  logic [DATA_W-1:0] bus_rdata_i,
  input  logic              bus_ack_i,
  output logic              bus_err_o
);

  localparam int TW = $clog2(TIMEOUT + 1);
  localparam logic [TW-1:0] TLAST = TW'(TIMEOUT - 1);

  typedef enum logic {IDLE, BUSY} state_t;

  state_t            state;
  logic              hold_valid;
  logic [ADDR_W-1:0] hold_addr;
  logic [DATA_W-1:0] hold_data;
  logic [TW-1:0]     tcnt;

  logic aligned, hit, miss;

  assign aligned    = (rom_addr_i[1:0] == 2'b00);
  assign hit        = rom_ce_i && aligned && hold_valid && (hold_addr == rom_addr_i);
  assign miss       = rom_ce_i && aligned && !hit;
  assign misalign_o = rom_ce_i && !aligned;
  assign stallreq_o = miss;
  assign rom_data_o = hit ? hold_data : '0;

  // The in-flight request is never cancelled; a redirect simply re-misses from IDLE.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      hold_valid <= 1'b0;
      hold_addr  <= '0;
      hold_data  <= '0;
      tcnt       <= '0;
      bus_req_o  <= 1'b0;
      bus_addr_o <= '0;
      bus_err_o  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (miss) begin
            bus_req_o  <= 1'b1;
            bus_addr_o <= rom_addr_i;
            tcnt       <= '0;
            state      <= BUSY;
          end
        end
        BUSY: begin
          // Ack wins over a coincident timeout.
          if (bus_ack_i) begin
            hold_valid <= 1'b1;
            hold_addr  <= bus_addr_o;
            hold_data  <= bus_rdata_i;
            bus_req_o  <= 1'b0;
            state      <= IDLE;
          end else if (tcnt == TLAST) begin
            hold_valid <= 1'b1;
            hold_addr  <= bus_addr_o;
            hold_data  <= '0;
            bus_req_o  <= 1'b0;
            bus_err_o  <= 1'b1;
            state      <= IDLE;
          end else begin
            tcnt <= tcnt + 1'b1;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_inst_fetch_bridge.sv
// Directed and randomized checks of inst_fetch_bridge against a transaction-level model.
module tb_inst_fetch_bridge;

  localparam int TO = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        rom_ce_i = 1'b0;
  logic [31:0] rom_addr_i = '0;
  logic [31:0] rom_data_o;
  logic        stallreq_o, misalign_o, bus_req_o, bus_err_o;
  logic [31:0] bus_addr_o;
  logic [31:0] bus_rdata_i = '0;
  logic        bus_ack_i = 1'b0;

  inst_fetch_bridge #(.ADDR_W(32), .DATA_W(32), .TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst), .rom_ce_i(rom_ce_i), .rom_addr_i(rom_addr_i),
    .rom_data_o(rom_data_o), .stallreq_o(stallreq_o), .misalign_o(misalign_o),
    .bus_req_o(bus_req_o), .bus_addr_o(bus_addr_o), .bus_rdata_i(bus_rdata_i),
    .bus_ack_i(bus_ack_i), .bus_err_o(bus_err_o)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  // reference model: cached word, outstanding request with its age in request cycles
  bit          m_hv, m_busy, m_err;
  logic [31:0] m_ha, m_hd, m_addr;
  int          m_age;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    if (obs !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_hv = 0; m_busy = 0; m_err = 0;
    m_ha = '0; m_hd = '0; m_addr = '0; m_age = 0;
  endtask

  // one clock: drive inputs on the falling edge, check, then advance the model at the rising edge
  task automatic cycle(input bit ce, input logic [31:0] a, input bit ack, input logic [31:0] rd);
    bit al, h, stall;
    @(negedge clk);
    rom_ce_i = ce; rom_addr_i = a; bus_ack_i = ack; bus_rdata_i = rd;
    #1;
    al    = (a % 4) == 0;
    h     = ce && al && m_hv && (m_ha == a);
    stall = ce && al && !h;
    chk("rom_data", rom_data_o, h ? m_hd : 32'h0);
    chk("stallreq", 32'(stallreq_o), 32'(stall));
    chk("misalign", 32'(misalign_o), 32'(ce && !al));
    chk("bus_req", 32'(bus_req_o), 32'(m_busy));
    if (m_busy) chk("bus_addr", bus_addr_o, m_addr);
    chk("bus_err", 32'(bus_err_o), 32'(m_err));
    @(posedge clk);
    if (m_busy) begin
      m_age++;
      if (ack) begin
        m_hv = 1; m_ha = m_addr; m_hd = rd; m_busy = 0;
      end else if (m_age == TO) begin
        m_hv = 1; m_ha = m_addr; m_hd = '0; m_busy = 0; m_err = 1;
      end
    end else if (stall) begin
      m_busy = 1; m_addr = a; m_age = 0;
    end
  endtask

  // asserted between edges; outputs must clear before the next rising edge
  task automatic do_reset();
    #2;
    rst = 1'b1;
    #1;
    model_reset();
    chk("rst_bus_req", 32'(bus_req_o), 32'h0);
    chk("rst_bus_err", 32'(bus_err_o), 32'h0);
    chk("rst_bus_addr", bus_addr_o, 32'h0);
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  logic [31:0] pool [8] = '{32'h0, 32'h4, 32'h8, 32'hC, 32'h40, 32'h44, 32'h6, 32'h11};

  initial begin
    logic [31:0] pc;
    bit          ce, ack;
    model_reset();
    @(posedge clk);
    do_reset();

    // cold miss, acked on the third request cycle
    cycle(1, 32'h0, 0, 32'h0);
    cycle(1, 32'h0, 0, 32'h0);
    cycle(1, 32'h0, 0, 32'h0);
    cycle(1, 32'h0, 1, 32'h34010001);
    for (int i = 0; i < 5; i++) cycle(1, 32'h0, 0, 32'hDEADBEEF);
    chk("cold_hit_data", rom_data_o, 32'h34010001);
    // immediate ack
    cycle(1, 32'h4, 0, 32'h0);
    cycle(1, 32'h4, 1, 32'h00011020);
    cycle(1, 32'h4, 0, 32'h0);
    // redirect while busy
    cycle(1, 32'h8, 0, 32'h0);
    cycle(1, 32'h40, 0, 32'h0);
    cycle(1, 32'h40, 1, 32'hAAAA0000);
    cycle(1, 32'h40, 0, 32'h0);
    cycle(1, 32'h40, 1, 32'h12345678);
    cycle(1, 32'h40, 0, 32'h0);
    // timeout
    for (int i = 0; i < TO + 1; i++) cycle(1, 32'h10, 0, 32'h0);
    cycle(1, 32'h10, 0, 32'h0);
    chk("timeout_err", 32'(bus_err_o), 32'h1);
    cycle(1, 32'h14, 1, 32'h0);
    // misaligned and disabled
    cycle(1, 32'h6, 0, 32'h0);
    cycle(0, 32'h10, 1, 32'h0);
    cycle(1, 32'h10, 0, 32'h0);
    // ack coincident with the last timeout cycle
    do_reset();
    for (int i = 0; i < TO; i++) cycle(1, 32'h20, 0, 32'h0);
    cycle(1, 32'h20, 1, 32'hCAFEF00D);
    cycle(1, 32'h20, 0, 32'h0);
    chk("simul_no_err", 32'(bus_err_o), 32'h0);
    // reset mid-request, late ack ignored
    cycle(1, 32'h30, 0, 32'h0);
    cycle(1, 32'h30, 0, 32'h0);
    do_reset();
    cycle(0, 32'h30, 1, 32'h55555555);
    cycle(1, 32'h30, 0, 32'h0);
    cycle(1, 32'h30, 1, 32'h66666666);
    cycle(1, 32'h30, 0, 32'h0);

    // randomized phase
    pc = 32'h0;
    for (int n = 0; n < 3000; n++) begin
      if ($urandom_range(0, 99) < 15) pc = pool[$urandom_range(0, 7)];
      ce  = $urandom_range(0, 99) < 90;
      ack = m_busy ? ($urandom_range(0, 99) < 30) : ($urandom_range(0, 99) < 5);
      cycle(ce, pc, ack, $urandom);
      if ($urandom_range(0, 999) < 3) do_reset();
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
